// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the alignment predicate used when DMEM_ALIGN_CHECK_EN is defined.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
      return ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane data array with synchronous read/write; the registered read word
// is cleared by reset and can be forced to zero for a rejected access.
module dmem_bank #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [3:0]                     we,
   input  logic                           clr,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    q
);

   logic [31:0] mem [DEPTH_WORDS];

   // Array contents are deliberately never reset.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= clr ? '0 : mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: IDLE/WAIT/RESP FSM with a down-counter.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [3:0]  req_wen,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        resp_valid,
   output logic        resp_err
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t          state, next_state;
   logic [3:0]      cnt;
   logic [AW-1:0]   lat_idx;
   logic [3:0]      lat_wen;
   logic [31:0]     lat_wdata;
   logic            accept;
   logic            enter_resp;
   logic [AW-1:0]   cur_idx;
   logic [3:0]      cur_wen;
   logic [31:0]     cur_wdata;
   logic            cur_err;

   assign accept = (state == ST_IDLE) && req_en;

   // With zero wait states the bank is written straight from the request inputs.
   assign cur_idx   = accept ? req_addr[AW+1:2] : lat_idx;
   assign cur_wen   = accept ? req_wen          : lat_wen;
   assign cur_wdata = accept ? req_wdata        : lat_wdata;

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (req_en) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (cnt == 4'd0) next_state = ST_RESP;
         ST_RESP: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP) && !rst;
   assign busy       = accept || (state == ST_WAIT);
   assign resp_valid = (state == ST_RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         if (accept) begin
            cnt <= CNT_LOAD;
         end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_idx   <= req_addr[AW+1:2];
         lat_wen   <= req_wen;
         lat_wdata <= req_wdata;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   logic [1:0] lat_lsb;
   logic [1:0] lat_size;
   logic       err_q;

   always_ff @(posedge clk) begin
      if (accept) begin
         lat_lsb  <= req_addr[1:0];
         lat_size <= req_size;
      end
   end

   assign cur_err = accept ? misaligned(req_size, req_addr[1:0]) : misaligned(lat_size, lat_lsb);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (enter_resp) begin
         err_q <= cur_err;
      end else if (state == ST_RESP) begin
         err_q <= 1'b0;
      end
   end

   assign resp_err = err_q;
`else
   assign cur_err  = 1'b0;
   assign resp_err = 1'b0;
`endif

   dmem_bank #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .en    (enter_resp),
      .we    (cur_err ? 4'b0000 : cur_wen),
      .clr   (cur_err),
      .idx   (cur_idx),
      .wdata (cur_wdata),
      .q     (rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 3 wait states) checked
// against a word-array model with table vectors, hand sequences and random traffic.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst        [3];
   logic        req_en     [3];
   logic [3:0]  req_wen    [3];
   logic [1:0]  req_size   [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic [31:0] rdata      [3];
   logic        busy       [3];
   logic        resp_valid [3];
   logic        resp_err   [3];

   int wc [3] = '{1, 0, 3};

   logic [31:0] mdl   [3][DEPTH];
   bit          known [3][DEPTH];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst[0]), .req_en(req_en[0]), .req_wen(req_wen[0]),
      .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rdata(rdata[0]), .busy(busy[0]), .resp_valid(resp_valid[0]), .resp_err(resp_err[0]));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst[1]), .req_en(req_en[1]), .req_wen(req_wen[1]),
      .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rdata(rdata[1]), .busy(busy[1]), .resp_valid(resp_valid[1]), .resp_err(resp_err[1]));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst[2]), .req_en(req_en[2]), .req_wen(req_wen[2]),
      .req_size(req_size[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rdata(rdata[2]), .busy(busy[2]), .resp_valid(resp_valid[2]), .resp_err(resp_err[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   // One request issued at the next cycle; req_en stays high through the response
   // cycle, as a stalled core would keep it.
   task automatic access(input int k, input logic [3:0] wen, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got_rd, output logic got_err);
      int          idx;
      bit          err;
      logic [31:0] exp_rd;
      bit          rd_known;
      bit          seen;
      int          lat;
      idx      = int'((addr >> 2) % DEPTH);
      err      = ALIGN && (((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00)));
      exp_rd   = err ? 32'h0 : mdl[k][idx];
      rd_known = err || known[k][idx];

      @(posedge clk); #1;
      req_en[k] = 1'b1; req_wen[k] = wen; req_size[k] = size;
      req_addr[k] = addr; req_wdata[k] = wdata;
      #1;
      chk($sformatf("busy_at_accept[%0d]", k), 32'(busy[k]), 32'd1);

      seen = 0; lat = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(posedge clk); #1;
         if (resp_valid[k]) begin
            seen = 1; lat = c;
         end else begin
            chk($sformatf("busy_in_wait[%0d]", k), 32'(busy[k]), 32'd1);
         end
      end
      chk($sformatf("resp_latency[%0d]", k), lat, wc[k] + 1);
      got_rd = rdata[k]; got_err = resp_err[k];
      if (seen) begin
         chk($sformatf("busy_in_resp[%0d]", k), 32'(busy[k]), 32'd0);
         chk($sformatf("resp_err[%0d]", k), 32'(resp_err[k]), 32'(err));
         if (rd_known) chk($sformatf("rdata[%0d]@%08h", k, addr), rdata[k], exp_rd);
      end

      if (!err) begin
         for (int i = 0; i < 4; i++)
            if (wen[i]) mdl[k][idx][8*i +: 8] = wdata[8*i +: 8];
         if (wen == 4'hF) known[k][idx] = 1'b1;
      end
   endtask

   task automatic idle(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req_en[k] = 1'b0;
         #1;
         chk($sformatf("idle_no_resp[%0d]", k), 32'(resp_valid[k]), 32'd0);
         chk($sformatf("idle_no_busy[%0d]", k), 32'(busy[k]), 32'd0);
      end
   endtask

   typedef struct {
      logic [3:0]  wen;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [31:0] rd;
      logic        er;

      tbl[0] = '{4'hF, 2'b10, 32'h100,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
      tbl[1] = '{4'h0, 2'b10, 32'h100,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
      tbl[2] = '{4'hF, 2'b10, 32'h20,   32'h11223344, 1'b0, 32'h0,        1'b0};
      tbl[3] = '{4'h4, 2'b00, 32'h22,   32'h00AA0000, 1'b1, 32'h11223344, 1'b0};
      tbl[4] = '{4'h0, 2'b10, 32'h20,   32'h0,        1'b1, 32'h11AA3344, 1'b0};
      if (ALIGN) begin
         tbl[5] = '{4'hF, 2'b10, 32'h102,  32'hCAFEF00D, 1'b1, 32'h0,        1'b1};
         tbl[6] = '{4'h0, 2'b10, 32'h100,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
         tbl[7] = '{4'h0, 2'b10, 32'h1100, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
      end else begin
         tbl[5] = '{4'hF, 2'b10, 32'h102,  32'hCAFEF00D, 1'b1, 32'hDEADBEEF, 1'b0};
         tbl[6] = '{4'h0, 2'b10, 32'h100,  32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
         tbl[7] = '{4'h0, 2'b10, 32'h1100, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
      end

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; req_en[k] = 1'b0; req_wen[k] = '0; req_size[k] = '0;
         req_addr[k] = '0; req_wdata[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_rdata[%0d]", k), rdata[k], 32'h0);
         chk($sformatf("reset_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
         chk($sformatf("reset_err[%0d]", k), 32'(resp_err[k]), 32'd0);
         chk($sformatf("reset_busy[%0d]", k), 32'(busy[k]), 32'd0);
         rst[k] = 1'b0;
      end

      // Directed vectors on the single-wait-state instance.
      for (int v = 0; v < 8; v++) begin
         access(0, tbl[v].wen, tbl[v].size, tbl[v].addr, tbl[v].wdata, rd, er);
         if (tbl[v].chk_rd) chk($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rd);
         chk($sformatf("vec%0d_err", v), 32'(er), 32'(tbl[v].exp_err));
      end
      idle(0, 2);

      // Zero wait states: back-to-back requests with req_en held through each response.
      access(1, 4'hF, 2'b10, 32'h300, 32'hA5A5_0001, rd, er);
      access(1, 4'hF, 2'b10, 32'h304, 32'hA5A5_0002, rd, er);
      access(1, 4'h0, 2'b10, 32'h300, 32'h0, rd, er);
      chk("b2b_read0", rd, 32'hA5A5_0001);
      access(1, 4'h0, 2'b10, 32'h304, 32'h0, rd, er);
      chk("b2b_read1", rd, 32'hA5A5_0002);
      idle(1, 3);

      // Reset during the second wait cycle of a write aborts it.
      access(2, 4'hF, 2'b10, 32'h40, 32'h0BADF00D, rd, er);
      @(posedge clk); #1;
      req_en[2] = 1'b1; req_wen[2] = 4'hF; req_size[2] = 2'b10;
      req_addr[2] = 32'h40; req_wdata[2] = 32'h12345678;
      @(posedge clk); #1;
      chk("abort_busy_wait1", 32'(busy[2]), 32'd1);
      @(posedge clk); #1;
      chk("abort_busy_wait2", 32'(busy[2]), 32'd1);
      rst[2] = 1'b1; req_en[2] = 1'b0;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      #1;
      chk("abort_valid", 32'(resp_valid[2]), 32'd0);
      chk("abort_rdata", rdata[2], 32'h0);
      chk("abort_busy", 32'(busy[2]), 32'd0);
      idle(2, 6);
      access(2, 4'h0, 2'b10, 32'h40, 32'h0, rd, er);
      chk("abort_old_value", rd, 32'h0BADF00D);
      idle(2, 1);

      // Random traffic over a 16-word pool, with address aliases beyond the array.
      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < 16; w++)
            access(k, 4'hF, 2'b10, 32'h800 + 32'(w * 4), $urandom, rd, er);
         for (int n = 0; n < 150; n++) begin
            logic [3:0]  wen;
            logic [31:0] addr;
            wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            addr = 32'h800 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3))
                   + 32'($urandom_range(0, 3) * DEPTH * 4);
            access(k, wen, 2'($urandom_range(0, 2)), addr, $urandom, rd, er);
            idle(k, $urandom_range(0, 2));
         end
         idle(k, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit words in the memory array (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set the number of wait-state cycles per access (range 0..15).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_en  input  1  core memory request in M stage; held stable while busy is high.
REQ-006 req_wen  input  4  byte-lane write enables; 4'b0000 means read.
REQ-007 req_size  input  2  access size: 00 byte, 01 half, 10 word.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  lane-aligned write data.
REQ-010 rdata  output  32  full read word, registered.
REQ-011 busy  output  1  stall request to the hazard unit.
REQ-012 resp_valid  output  1  one-cycle response strobe.
REQ-013 resp_err  output  1  alignment error flag, qualified by resp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-015 In IDLE with req_en=1 at cycle T, the block SHALL latch addr/wen/wdata/size and go to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-016 busy SHALL be combinationally high in IDLE when req_en=1, high throughout WAIT, and low in RESP and otherwise.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, using a down-counter loaded with WAIT_CYCLES-1 on acceptance, then go to RESP.
REQ-018 resp_valid SHALL be high for exactly one cycle, in RESP, at cycle T+1+WAIT_CYCLES.
REQ-019 A write SHALL update only the lanes set in the latched wen, at word index addr[log2(DEPTH_WORDS)+1:2], on the clock edge entering RESP.
REQ-020 rdata SHALL load the addressed word (pre-write contents for writes) on the edge entering RESP and hold until the next response.
REQ-021 Addresses beyond DEPTH_WORDS SHALL wrap modulo the array size.
REQ-022 RESP SHALL always return to IDLE. req_en seen in RESP SHALL be ignored, because it is the same request still held by the core.
REQ-023 Request inputs SHALL be ignored while in WAIT.

Reset
REQ-024 rst SHALL force IDLE, rdata=0, resp_valid=0, resp_err=0 and counter=0. busy SHALL then follow REQ-016.
REQ-025 rst asserted during WAIT SHALL abort the access with no memory write. Array contents SHALL NOT be reset.

Configuration
REQ-026 With DMEM_ALIGN_CHECK_EN defined, half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 SHALL suppress the write, return rdata=0 and set resp_err=1 in RESP.
REQ-027 Without DMEM_ALIGN_CHECK_EN, resp_err SHALL be tied 0 and addr[1:0] and size SHALL NOT affect the access.

Structure
REQ-028 The shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-029 The byte-lane memory array SHALL be the sub-module dmem_bank (synchronous read/write, 4 byte-wide write enables). The FSM and counter SHALL be in dmem_responder.

Verification
REQ-030 Word write then read, WAIT_CYCLES=1: write 0xDEADBEEF to 0x100, wen=1111, then read 0x100 -> busy high 2 cycles per access, resp_valid at T+2, rdata=0xDEADBEEF.
REQ-031 Byte lanes: word 0x11223344 at 0x20, then byte write wen=0100 with wdata=0x00AA0000 -> read gives 0x11AA3344.
REQ-032 WAIT_CYCLES=0: read accepted at T -> busy high only at T, resp_valid at T+1, no gap back-to-back on the next request.
REQ-033 Hold-over: req_en kept high through RESP -> exactly one resp_valid and one write per request.
REQ-034 Reset mid-WAIT (WAIT_CYCLES=3): rst in the 2nd wait cycle of a write to 0x40 -> later read of 0x40 returns the old value, resp_valid stays 0 until a new request.
REQ-035 DMEM_ALIGN_CHECK_EN defined: word write to 0x102 -> resp_err=1, rdata=0, memory unchanged. Macro undefined -> resp_err=0 and the write lands at word 0x100.
